// File: rtl/conv_mc_engine.sv
// ---------------------------------------------------------------------------
// conv_mc_engine
//
// Multi-channel 2-D convolution engine. A run walks a cfg_h x cfg_w image held
// in an external feature buffer (channel-major, then row-major), accumulates
// K x K taps over cfg_ch input channels for every valid output position, adds
// a bias, requantises with an arithmetic right shift, optionally applies ReLU
// and saturates to 8 bits. Each output pixel is emitted with its row-major
// output address over a valid/ready handshake.
//
// Optional feature macro: CONV_ROUND_EN
//   defined   -> round half up before the requant shift (when cfg_shift > 0)
//   undefined -> plain truncating arithmetic shift
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               run request, sampled only while idle
//   i_cfg_h / i_cfg_w     image rows / columns (sampled with i_start)
//   i_cfg_ch              input channel count, 1..MAX_CH
//   i_cfg_shift           requant right shift
//   i_cfg_relu            1: ReLU + [0,255] clamp, 0: [-128,127] clamp
//   i_cfg_bias            signed bias added before the shift
//   o_busy, o_done        run in progress / one-cycle end-of-run pulse
//   o_img_rd_en           image + weight read strobe
//   o_img_addr, o_wt_addr read addresses; data returns one cycle later
//   i_img_data, i_wt_data unsigned pixel / signed weight read data
//   o_out_valid           output pixel valid, held until i_out_ready
//   o_out_data, o_out_addr result pixel and its row-major output address
// ---------------------------------------------------------------------------
module conv_mc_engine #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned K       = 3,
    parameter int unsigned MAX_H   = 16,
    parameter int unsigned MAX_W   = 16,
    parameter int unsigned MAX_CH  = 4,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned IADDR_W = 10,
    parameter int unsigned WADDR_W = 6,
    parameter int unsigned OADDR_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [4:0]         i_cfg_h,
    input  logic [4:0]         i_cfg_w,
    input  logic [2:0]         i_cfg_ch,
    input  logic [3:0]         i_cfg_shift,
    input  logic               i_cfg_relu,
    input  logic [15:0]        i_cfg_bias,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_img_rd_en,
    output logic [IADDR_W-1:0] o_img_addr,
    input  logic [DATA_W-1:0]  i_img_data,
    output logic [WADDR_W-1:0] o_wt_addr,
    input  logic [DATA_W-1:0]  i_wt_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [7:0]         o_out_data,
    output logic [OADDR_W-1:0] o_out_addr
);

    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
    // Two guard bits: one for the bias add, one for the rounding add.
    localparam int unsigned VW = ACC_W + 2;
    localparam int unsigned PW = 2 * DATA_W + 1;

    localparam logic [KW-1:0]        KLast = KW'(K - 1);
    localparam logic signed [VW-1:0] Zero  = '0;
    localparam logic signed [VW-1:0] MaxU  = VW'(255);
    localparam logic signed [VW-1:0] MaxS  = VW'(127);
    localparam logic signed [VW-1:0] MinS  = VW'(-128);

    typedef enum logic [2:0] {
        StIdle,
        StMac,
        StDrain,
        StPost,
        StOut,
        StDone
    } state_e;

    state_e                    r_state;

    // Latched run configuration
    logic [4:0]                r_h;
    logic [4:0]                r_w;
    logic [2:0]                r_ch;
    logic [3:0]                r_shift;
    logic                      r_relu;
    logic signed [15:0]        r_bias;

    // Output pixel position and tap currently being addressed
    logic [4:0]                r_row;
    logic [4:0]                r_col;
    logic [2:0]                r_tc;
    logic [KW-1:0]             r_tki;
    logic [KW-1:0]             r_tkj;

    // r_dv marks the cycle in which read data for last cycle's address is present
    logic                      r_dv;
    logic signed [ACC_W-1:0]   r_acc;

    logic                      r_busy;
    logic                      r_done;
    logic                      r_img_rd_en;
    logic [IADDR_W-1:0]        r_img_addr;
    logic [WADDR_W-1:0]        r_wt_addr;
    logic                      r_out_valid;
    logic [7:0]                r_out_data;
    logic [OADDR_W-1:0]        r_out_addr;

    logic                      w_cfg_bad;
    logic                      w_last_tap;
    logic [2:0]                w_nc;
    logic [KW-1:0]             w_nki;
    logic [KW-1:0]             w_nkj;
    logic                      w_last_col;
    logic                      w_last_row;
    logic [4:0]                w_next_row;
    logic [4:0]                w_next_col;
    logic signed [PW-1:0]      w_pix_x;
    logic signed [PW-1:0]      w_wt_x;
    logic signed [PW-1:0]      w_prod;
    logic signed [VW-1:0]      w_sum;
    logic signed [VW-1:0]      w_round;
    logic signed [VW-1:0]      w_shifted;
    logic [7:0]                w_res;

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_img_rd_en = r_img_rd_en;
    assign o_img_addr  = r_img_addr;
    assign o_wt_addr   = r_wt_addr;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_addr  = r_out_addr;

    function automatic logic [IADDR_W-1:0] f_img_addr(
        input logic [2:0]    c,
        input logic [4:0]    row,
        input logic [4:0]    col,
        input logic [KW-1:0] ki,
        input logic [KW-1:0] kj,
        input logic [4:0]    h,
        input logic [4:0]    w
    );
        return IADDR_W'(32'(c) * 32'(h) * 32'(w) + (32'(row) + 32'(ki)) * 32'(w)
                        + 32'(col) + 32'(kj));
    endfunction

    function automatic logic [WADDR_W-1:0] f_wt_addr(
        input logic [2:0]    c,
        input logic [KW-1:0] ki,
        input logic [KW-1:0] kj
    );
        return WADDR_W'(32'(c) * K * K + 32'(ki) * K + 32'(kj));
    endfunction

    always_comb begin
        w_cfg_bad = (32'(i_cfg_h) < K) || (32'(i_cfg_w) < K) ||
                    (32'(i_cfg_h) > MAX_H) || (32'(i_cfg_w) > MAX_W) ||
                    (i_cfg_ch == 3'd0) || (32'(i_cfg_ch) > MAX_CH);
    end

    // Tap sequencing: channel slowest, kj fastest
    always_comb begin
        w_last_tap = (r_tc == r_ch - 3'd1) && (r_tki == KLast) && (r_tkj == KLast);
        w_nc  = r_tc;
        w_nki = r_tki;
        w_nkj = r_tkj;
        if (r_tkj != KLast) begin
            w_nkj = r_tkj + 1'b1;
        end else begin
            w_nkj = '0;
            if (r_tki != KLast) begin
                w_nki = r_tki + 1'b1;
            end else begin
                w_nki = '0;
                w_nc  = r_tc + 3'd1;
            end
        end
    end

    // Output position sequencing, row-major
    always_comb begin
        w_last_col = (32'(r_col) == 32'(r_w) - K);
        w_last_row = (32'(r_row) == 32'(r_h) - K);
        w_next_row = r_row;
        w_next_col = r_col + 5'd1;
        if (w_last_col) begin
            w_next_col = 5'd0;
            w_next_row = r_row + 5'd1;
        end
    end

    // Tap product: unsigned pixel times signed weight, full precision
    always_comb begin
        w_pix_x = signed'({{(DATA_W + 1){1'b0}}, i_img_data});
        w_wt_x  = signed'({{(DATA_W + 1){i_wt_data[DATA_W-1]}}, i_wt_data});
        w_prod  = w_pix_x * w_wt_x;
    end

    // Bias, requant shift, ReLU and saturation
    always_comb begin
        w_sum = VW'(r_acc) + VW'(r_bias);
`ifdef CONV_ROUND_EN
        w_round = (r_shift != 4'd0) ? (VW'(1) << (r_shift - 4'd1)) : Zero;
`else
        w_round = Zero;
`endif
        w_shifted = (w_sum + w_round) >>> r_shift;
        if (r_relu) begin
            if (w_shifted < Zero) begin
                w_res = 8'h00;
            end else if (w_shifted > MaxU) begin
                w_res = 8'hFF;
            end else begin
                w_res = w_shifted[7:0];
            end
        end else begin
            if (w_shifted > MaxS) begin
                w_res = 8'h7F;
            end else if (w_shifted < MinS) begin
                w_res = 8'h80;
            end else begin
                w_res = w_shifted[7:0];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_h         <= '0;
            r_w         <= '0;
            r_ch        <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_bias      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_tc        <= '0;
            r_tki       <= '0;
            r_tkj       <= '0;
            r_dv        <= 1'b0;
            r_acc       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_img_rd_en <= 1'b0;
            r_img_addr  <= '0;
            r_wt_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
        end else begin
            r_dv <= r_img_rd_en;
            if (r_dv) begin
                r_acc <= r_acc + ACC_W'(w_prod);
            end

            unique case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_h     <= i_cfg_h;
                        r_w     <= i_cfg_w;
                        r_ch    <= i_cfg_ch;
                        r_shift <= i_cfg_shift;
                        r_relu  <= i_cfg_relu;
                        r_bias  <= signed'(i_cfg_bias);
                        r_row   <= '0;
                        r_col   <= '0;
                        r_tc    <= '0;
                        r_tki   <= '0;
                        r_tkj   <= '0;
                        if (w_cfg_bad) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            // First tap of pixel (0,0) is address 0 in both buffers
                            r_state     <= StMac;
                            r_busy      <= 1'b1;
                            r_img_rd_en <= 1'b1;
                            r_img_addr  <= '0;
                            r_wt_addr   <= '0;
                            r_acc       <= '0;
                        end
                    end
                end

                StMac: begin
                    if (w_last_tap) begin
                        r_state     <= StDrain;
                        r_img_rd_en <= 1'b0;
                    end else begin
                        r_tc       <= w_nc;
                        r_tki      <= w_nki;
                        r_tkj      <= w_nkj;
                        r_img_addr <= f_img_addr(w_nc, r_row, r_col, w_nki, w_nkj, r_h, r_w);
                        r_wt_addr  <= f_wt_addr(w_nc, w_nki, w_nkj);
                    end
                end

                // The last tap's data is accumulated by the r_dv path above
                StDrain: begin
                    r_state <= StPost;
                end

                StPost: begin
                    r_out_data  <= w_res;
                    r_out_addr  <= OADDR_W'(32'(r_row) * (32'(r_w) - K + 1) + 32'(r_col));
                    r_out_valid <= 1'b1;
                    r_state     <= StOut;
                end

                StOut: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last_col && w_last_row) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_row       <= w_next_row;
                            r_col       <= w_next_col;
                            r_tc        <= '0;
                            r_tki       <= '0;
                            r_tkj       <= '0;
                            r_img_addr  <= f_img_addr(3'd0, w_next_row, w_next_col, '0, '0,
                                                      r_h, r_w);
                            r_wt_addr   <= '0;
                            r_img_rd_en <= 1'b1;
                            r_acc       <= '0;
                            r_state     <= StMac;
                        end
                    end
                end

                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mc_engine.sv
// ---------------------------------------------------------------------------
// tb_conv_mc_engine
//
// Directed bench for conv_mc_engine: ramp image, clamp corners, two-channel
// requant (with or without CONV_ROUND_EN), output backpressure, invalid
// configuration, start/cfg changes mid-run and reset mid-run. Cycle numbers
// count from the idle cycle in which start is sampled (cycle 0).
// ---------------------------------------------------------------------------
module tb_conv_mc_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  cfg_h;
    logic [4:0]  cfg_w;
    logic [2:0]  cfg_ch;
    logic [3:0]  cfg_shift;
    logic        cfg_relu;
    logic [15:0] cfg_bias;
    logic        busy;
    logic        done;
    logic        img_rd_en;
    logic [9:0]  img_addr;
    logic [7:0]  img_data;
    logic [5:0]  wt_addr;
    logic [7:0]  wt_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [7:0]  out_addr;

    always #5 clk = ~clk;

    conv_mc_engine dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_cfg_h     (cfg_h),
        .i_cfg_w     (cfg_w),
        .i_cfg_ch    (cfg_ch),
        .i_cfg_shift (cfg_shift),
        .i_cfg_relu  (cfg_relu),
        .i_cfg_bias  (cfg_bias),
        .o_busy      (busy),
        .o_done      (done),
        .o_img_rd_en (img_rd_en),
        .o_img_addr  (img_addr),
        .i_img_data  (img_data),
        .o_wt_addr   (wt_addr),
        .i_wt_data   (wt_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_addr  (out_addr)
    );

    // Feature and weight buffers with one cycle read latency
    logic [7:0] img_mem [0:1023];
    logic [7:0] wt_mem  [0:63];

    always @(posedge clk) begin
        if (img_rd_en) begin
            img_data <= img_mem[img_addr];
            wt_data  <= wt_mem[wt_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Results of the most recent run
    int         n_out;
    int         first_valid;
    int         done_cyc;
    int         busy_at_done;
    int         hs1_cyc;
    int         rd_after_hs1;
    int         rd_in_stall;
    int         unstable;
    int         busy_seen;
    int         valid_seen;
    logic [7:0] out_d [0:15];
    logic [7:0] out_a [0:15];
    int         rd_en_log [0:31];
    int         rd_addr_log [0:31];
    int         wt_addr_log [0:31];

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) img_mem[i] = 8'd0;
        for (int i = 0; i < 64; i++) wt_mem[i] = 8'd0;
    endtask

    task automatic fill(input int is_img, input int base, input int n, input logic [7:0] val);
        for (int i = 0; i < n; i++) begin
            if (is_img != 0) img_mem[base + i] = val;
            else wt_mem[base + i] = val;
        end
    endtask

    task automatic load_ramp5();
        clear_mem();
        for (int i = 0; i < 25; i++) img_mem[i] = 8'(i);
        fill(0, 0, 9, 8'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ctrl"}, {28'd0, busy, done, img_rd_en, out_valid}, 32'd0);
        check_eq({tag, "_data"}, {24'd0, out_data}, 32'd0);
        check_eq({tag, "_addr"}, {8'd0, out_addr, img_addr, wt_addr}, 32'd0);
    endtask

    // One run: stall = cycles of out_ready low at the first output,
    // spur = cycle with a spurious start (and cfg_w change), rst_at = cycle
    // in which rst is raised; every loop is bounded by budget.
    task automatic run(input int h, input int w, input int ch, input int sh, input int relu,
                       input int bias, input int stall, input int spur, input int rst_at,
                       input int budget);
        int         stall_left;
        logic [7:0] hold_d;
        logic [7:0] hold_a;
        n_out        = 0;
        first_valid  = -1;
        done_cyc     = -1;
        busy_at_done = -1;
        hs1_cyc      = -1;
        rd_after_hs1 = -1;
        rd_in_stall  = 0;
        unstable     = 0;
        busy_seen    = 0;
        valid_seen   = 0;
        hold_d       = 8'd0;
        hold_a       = 8'd0;
        stall_left   = stall;
        for (int i = 0; i < 32; i++) begin
            rd_en_log[i]   = 0;
            rd_addr_log[i] = 0;
            wt_addr_log[i] = 0;
        end
        @(negedge clk);
        cfg_h     = 5'(h);
        cfg_w     = 5'(w);
        cfg_ch    = 3'(ch);
        cfg_shift = 4'(sh);
        cfg_relu  = 1'(relu);
        cfg_bias  = 16'(bias);
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start = (k == spur);
            if (k == spur) cfg_w = 5'd3;
            if (k < 32) begin
                rd_en_log[k]   = int'(img_rd_en);
                rd_addr_log[k] = int'(img_addr);
                wt_addr_log[k] = int'(wt_addr);
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check_outputs_zero("rst_mid");
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                return;
            end
            if (busy) busy_seen = 1;
            if (done) begin
                done_cyc     = k;
                busy_at_done = int'(busy);
                start        = 1'b0;
                return;
            end
            if (out_valid) begin
                valid_seen = 1;
                if (first_valid < 0) begin
                    first_valid = k;
                    hold_d      = out_data;
                    hold_a      = out_addr;
                end
                if (n_out == 0 && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    if (out_data !== hold_d || out_addr !== hold_a) unstable++;
                    if (img_rd_en) rd_in_stall++;
                end else begin
                    out_ready = 1'b1;
                    if (n_out < 16) begin
                        out_d[n_out] = out_data;
                        out_a[n_out] = out_addr;
                    end
                    n_out++;
                    if (n_out == 1) hs1_cyc = k;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (hs1_cyc >= 0 && k > hs1_cyc && img_rd_en && rd_after_hs1 < 0) rd_after_hs1 = k;
        end
        start = 1'b0;
    endtask

    // Window sums of the 5x5 ramp with unit weights: 9 * centre pixel
    logic [7:0] ramp_exp [0:8] = '{8'd54, 8'd63, 8'd72, 8'd99, 8'd108, 8'd117,
                                   8'd144, 8'd153, 8'd162};

    initial begin
        int exp_2ch;
`ifdef CONV_ROUND_EN
        exp_2ch = 113;
`else
        exp_2ch = 112;
`endif
        rst       = 1'b1;
        start     = 1'b0;
        cfg_h     = '0;
        cfg_w     = '0;
        cfg_ch    = '0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        cfg_bias  = '0;
        out_ready = 1'b1;
        img_data  = '0;
        wt_data   = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Single-channel 5x5 ramp
        load_ramp5();
        run(5, 5, 1, 0, 1, 0, 0, 0, 0, 300);
        check_eq("ramp_count", n_out, 9);
        check_eq("ramp_first_valid", first_valid, 12);
        check_eq("ramp_done_cyc", done_cyc, 109);
        check_eq("ramp_busy_at_done", busy_at_done, 0);
        check_eq("ramp_rd_en_c1", rd_en_log[1], 1);
        check_eq("ramp_img_addr_c4", rd_addr_log[4], 5);
        check_eq("ramp_img_addr_c9", rd_addr_log[9], 12);
        check_eq("ramp_wt_addr_c9", wt_addr_log[9], 8);
        check_eq("ramp_rd_en_drain", rd_en_log[10], 0);
        check_eq("ramp_pix1_addr", rd_addr_log[13], 1);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("ramp_data%0d", i), out_d[i], ramp_exp[i]);
            check_eq($sformatf("ramp_addr%0d", i), out_a[i], i);
        end

        // Saturation corners on a 3x3 image of 255
        clear_mem();
        fill(1, 0, 9, 8'd255);
        fill(0, 0, 9, 8'd1);
        run(3, 3, 1, 0, 0, 0, 0, 0, 0, 100);
        check_eq("clamp_pos_count", n_out, 1);
        check_eq("clamp_pos_signed", out_d[0], 8'h7F);
        fill(0, 0, 9, 8'hFF);
        run(3, 3, 1, 0, 0, 0, 0, 0, 0, 100);
        check_eq("clamp_neg_signed", out_d[0], 8'h80);
        run(3, 3, 1, 0, 1, 0, 0, 0, 0, 100);
        check_eq("clamp_neg_relu", out_d[0], 8'h00);

        // Two channels with requant shift 2: (90 + 360) >> 2
        clear_mem();
        fill(1, 0, 9, 8'd10);
        fill(1, 9, 9, 8'd20);
        fill(0, 0, 9, 8'd1);
        fill(0, 9, 9, 8'd2);
        run(3, 3, 2, 2, 1, 0, 0, 0, 0, 100);
        check_eq("ch2_count", n_out, 1);
        check_eq("ch2_first_valid", first_valid, 21);
        check_eq("ch2_data", out_d[0], exp_2ch);
        check_eq("ch2_addr", out_a[0], 0);
        check_eq("ch2_done_cyc", done_cyc, 22);

        // Backpressure at the first output
        load_ramp5();
        run(5, 5, 1, 0, 1, 0, 5, 0, 0, 300);
        check_eq("bp_first_valid", first_valid, 12);
        check_eq("bp_unstable", unstable, 0);
        check_eq("bp_rd_in_stall", rd_in_stall, 0);
        check_eq("bp_handshake_cyc", hs1_cyc, 17);
        check_eq("bp_next_read_cyc", rd_after_hs1, 18);
        check_eq("bp_data0", out_d[0], 8'd54);
        check_eq("bp_count", n_out, 9);
        check_eq("bp_done_cyc", done_cyc, 114);

        // Invalid configurations
        run(5, 2, 1, 0, 1, 0, 0, 0, 0, 30);
        check_eq("bad_w_done_cyc", done_cyc, 1);
        check_eq("bad_w_valid_seen", valid_seen, 0);
        check_eq("bad_w_busy_seen", busy_seen, 0);
        run(5, 5, 0, 0, 1, 0, 0, 0, 0, 30);
        check_eq("bad_ch_done_cyc", done_cyc, 1);
        check_eq("bad_ch_count", n_out, 0);

        // Start pulse and cfg_w change mid-run are ignored
        run(5, 5, 1, 0, 1, 0, 0, 30, 0, 300);
        check_eq("spur_count", n_out, 9);
        check_eq("spur_done_cyc", done_cyc, 109);
        check_eq("spur_last_addr", out_a[8], 8);
        check_eq("spur_last_data", out_d[8], 8'd162);

        // Reset during MAC of the third pixel, then a clean rerun
        run(5, 5, 1, 0, 1, 0, 0, 0, 28, 300);
        check_eq("rst_count_before", n_out, 2);
        check_eq("rst_no_done", done_cyc, -1);
        run(5, 5, 1, 0, 1, 0, 0, 0, 0, 300);
        check_eq("rerun_data0", out_d[0], 8'd54);
        check_eq("rerun_addr0", out_a[0], 0);
        check_eq("rerun_count", n_out, 9);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_mc_engine.md
# conv_mc_engine

Parametrised multi-channel 2-D convolution engine; successor to the single-channel 3x3 conv unit. Per run it walks a runtime-sized image stored in an external feature buffer, accumulates K×K taps across up to MAX_CH input channels, adds a bias, requantises with an arithmetic right shift, applies optional ReLU and saturates. Each output pixel is emitted with its row-major address over a valid/ready handshake to the layer output buffer.

## Interface
- DATA_W, 8, pixel width (unsigned) and weight width (signed)
- K, 3, kernel height = width
- MAX_H, 16, maximum image rows
- MAX_W, 16, maximum image columns
- MAX_CH, 4, maximum input channels
- ACC_W, 24, accumulator width (signed)
- IADDR_W, 10, image read address width (≥ clog2(MAX_CH·MAX_H·MAX_W))
- WADDR_W, 6, weight read address width (≥ clog2(MAX_CH·K·K))
- OADDR_W, 8, output address width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- cfg_h, cfg_w  in  5 each  image rows/cols; sampled with start
- cfg_ch  in  3  input channel count, valid range 1..MAX_CH; sampled with start
- cfg_shift  in  4  requant right shift; sampled with start
- cfg_relu  in  1  1 = ReLU + unsigned clamp, 0 = signed clamp; sampled with start
- cfg_bias  in  16  signed bias; sampled with start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of run
- img_rd_en  out  1  image read strobe
- img_addr  out  IADDR_W  ch·H·W + r·W + c
- img_data  in  DATA_W  read data, valid 1 cycle after img_rd_en
- wt_addr  out  WADDR_W  ch·K·K + ki·K + kj; read together with img
- wt_data  in  DATA_W  signed weight, same 1-cycle latency
- out_valid  out  1  output pixel valid
- out_ready  in  1  consumer accepts pixel
- out_data  out  8  result pixel
- out_addr  out  OADDR_W  r·(cfg_w−K+1) + c

## Operation
- FSM: IDLE → MAC → DRAIN → POST → OUT → (MAC for next pixel | DONE) → IDLE.
- IDLE: on start, latch all cfg_*. If cfg_h<K, cfg_w<K, cfg_h>MAX_H, cfg_w>MAX_W, cfg_ch=0 or cfg_ch>MAX_CH → DONE directly, no outputs.
- MAC: N = cfg_ch·K·K cycles, one tap per cycle, order channel, ki, kj (kj fastest). Accumulator cleared on the first tap.
- Tap product: $signed({1'b0,pix}) × $signed(wt), 17 bits, sign-extended to ACC_W and added. No intermediate saturation.
- DRAIN: accumulate final returned tap. POST: v = acc + sext(bias); v = v >>> cfg_shift; if cfg_relu and v<0 → 0; clamp to [0,255] when cfg_relu, else [−128,127] as two's complement; register into out_data/out_addr.
- OUT: hold out_valid, out_data, out_addr stable until out_valid&&out_ready. No reads issued while stalled.
- Pixels are produced row-major. After the last pixel handshake → DONE (done=1, busy=0) → IDLE.
- start while busy is ignored. cfg_* changes mid-run have no effect.
- rst (any time): immediately return to IDLE; run is abandoned, no partial outputs or done.

## Timing
- Reset value of every output: 0 (busy, done, img_rd_en, img_addr, wt_addr, out_valid, out_data, out_addr).
- Cycle 0 = IDLE cycle in which start is sampled high. busy is high from cycle 1.
- Cycles 1..N: img_rd_en=1, one tap address per cycle. Cycle N+1: DRAIN. Cycle N+2: POST. Cycle N+3: out_valid=1.
- If out_ready is high in cycle N+3, the next pixel's first read is in cycle N+4. Per-pixel period is N+3 cycles under continuous ready.
- done pulses in the cycle after the final handshake; busy is low in that cycle. Invalid config: done in cycle 1, busy never high.

## Configuration
- CONV_ROUND_EN defined: when cfg_shift>0, add 1<<(cfg_shift−1) before the shift (round half up). Undefined: plain truncating arithmetic shift. With cfg_shift=0 the result is identical either way.

## Test plan
- 1 channel, 5×5 ramp pix=r·5+c, all weights 1, bias 0, shift 0, relu 1 -> 9 outputs, addr 0..8, first out_data=54, first out_valid in cycle 12, done after the 9th handshake.
- Clamp: pixels 255, weights all 1, relu 0 -> out_data 127 (0x7F); weights all −1, relu 0 -> 0x80; weights all −1, relu 1 -> 0.
- 2 channels, 3×3: ch0 pix 10 / wt 1, ch1 pix 20 / wt 2, bias 0, shift 2 -> single output 112, or 113 with CONV_ROUND_EN; first out_valid in cycle 21.
- Backpressure: out_ready low 5 cycles at the first output -> out_valid/out_data/out_addr stable, img_rd_en 0 throughout; first read of the next pixel in the cycle after the handshake.
- Invalid config cfg_w=2 -> done in cycle 1, out_valid never high. start pulsed mid-run -> ignored, output count unchanged.
- rst asserted during MAC of pixel 3 -> all outputs 0 immediately. A new start after release -> first out_data correct, addr 0.
